// File: rtl/pcie_tx_arb_pkg.sv
// Shared types and helpers for the PCIe TX arbiter: tuser bit map, FSM states,
// counter width and the round-robin next-grant function.
package pcie_tx_arb_pkg;

    localparam int TUSER_ECRC_GEN = 0;
    localparam int TUSER_ERR_FWD  = 1;
    localparam int TUSER_STR      = 2;
    localparam int TUSER_SRC_DSC  = 3;

    localparam int DROP_CNT_W = 16;

    typedef enum logic {
        ARB  = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    // First requester strictly after 'last', searched cyclically over n channels.
    function automatic logic [2:0] rr_next(input logic [7:0] req, input logic [2:0] last,
                                           input int n);
        logic [2:0] sel;
        int         idx;
        sel = last;
        for (int i = n; i >= 1; i--) begin
            idx = (int'(last) + i) % n;
            if (req[idx]) sel = 3'(idx);
        end
        return sel;
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry register buffer for an AXI4-Stream payload; ready toward the source
// depends only on registered occupancy, so there is no ready path through it.
module axis_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] in_data_i,
    input  logic         in_push_i,
    output logic         in_not_full_o,
    output logic [W-1:0] out_data_o,
    output logic         out_valid_o,
    input  logic         out_ready_i
);

    logic [1:0]   cnt_q, cnt_d;
    logic [W-1:0] s0_q, s0_d, s1_q, s1_d;
    logic         push, pop;

    assign in_not_full_o = (cnt_q != 2'd2);
    assign out_valid_o   = (cnt_q != 2'd0);
    assign out_data_o    = s0_q;
    assign pop           = out_valid_o && out_ready_i;
    assign push          = in_push_i && in_not_full_o;

    always_comb begin
        cnt_d = cnt_q;
        s0_d  = s0_q;
        s1_d  = s1_q;
        case (cnt_q)
            2'd0: begin
                if (push) begin
                    s0_d  = in_data_i;
                    cnt_d = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    s0_d = in_data_i;
                end else if (push) begin
                    s1_d  = in_data_i;
                    cnt_d = 2'd2;
                end else if (pop) begin
                    cnt_d = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    s0_d  = s1_q;
                    cnt_d = 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 2'd0;
            s0_q  <= '0;
            s1_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            s0_q  <= s0_d;
            s1_q  <= s1_d;
        end
    end

endmodule

// File: rtl/pcie_tx_arbiter.sv
// Packet-atomic round-robin merge of N_CH AXI4-Stream TLP sources onto the
// 7-series PCIe core TX port, gated on tx_buf_av, with a saturating drop counter.
module pcie_tx_arbiter
    import pcie_tx_arb_pkg::*;
#(
    parameter int N_CH         = 2,
    parameter int C_DATA_WIDTH = 64,
    parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8,
    parameter int BUF_MIN      = 2,
    localparam int GW          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                         user_clk,
    input  logic                         user_reset,
    input  logic [N_CH*C_DATA_WIDTH-1:0] s_tdata,
    input  logic [N_CH*KEEP_WIDTH-1:0]   s_tkeep,
    input  logic [N_CH*4-1:0]            s_tuser,
    input  logic [N_CH-1:0]              s_tlast,
    input  logic [N_CH-1:0]              s_tvalid,
    output logic [N_CH-1:0]              s_tready,
    output logic [C_DATA_WIDTH-1:0]      m_axis_tx_tdata,
    output logic [KEEP_WIDTH-1:0]        m_axis_tx_tkeep,
    output logic [3:0]                   m_axis_tx_tuser,
    output logic                         m_axis_tx_tlast,
    output logic                         m_axis_tx_tvalid,
    input  logic                         m_axis_tx_tready,
    input  logic [5:0]                   tx_buf_av,
    input  logic                         tx_err_drop,
    output logic [GW-1:0]                grant_ch,
    output logic                         busy,
    output logic [DROP_CNT_W-1:0]        drop_cnt
);

    localparam int PW = C_DATA_WIDTH + KEEP_WIDTH + 5;

    arb_state_e            state_q;
    logic [GW-1:0]         grant_q, last_q, next_grant;
    logic [DROP_CNT_W-1:0] drop_q;
    logic [7:0]            req8;
    logic                  skid_not_full, push, sel_valid, sel_last;
    logic [PW-1:0]         sel_payload;

    always_comb begin
        req8            = '0;
        req8[N_CH-1:0]  = s_tvalid;
    end

    assign next_grant = GW'(rr_next(req8, 3'(last_q), N_CH));

    // Only the granted channel's beat ever reaches the skid buffer.
    assign sel_valid   = s_tvalid[grant_q];
    assign sel_last    = s_tlast[grant_q];
    assign sel_payload = {sel_last,
                          s_tuser[int'(grant_q)*4 +: 4],
                          s_tkeep[int'(grant_q)*KEEP_WIDTH +: KEEP_WIDTH],
                          s_tdata[int'(grant_q)*C_DATA_WIDTH +: C_DATA_WIDTH]};
    assign push        = (state_q == XFER) && sel_valid && skid_not_full;

    always_comb begin
        s_tready = '0;
        if (state_q == XFER) s_tready[grant_q] = skid_not_full;
    end

    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            state_q <= ARB;
            grant_q <= '0;
            last_q  <= GW'(N_CH - 1);
        end else begin
            case (state_q)
                ARB: begin
                    if ((|s_tvalid) && (tx_buf_av >= 6'(BUF_MIN))) begin
                        grant_q <= next_grant;
                        last_q  <= next_grant;
                        state_q <= XFER;
                    end
                end
                default: begin
                    if (push && sel_last) state_q <= ARB;
                end
            endcase
        end
    end

    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            drop_q <= '0;
        end else if (tx_err_drop && (drop_q != '1)) begin
            drop_q <= drop_q + 1'b1;
        end
    end

    axis_skid_buf #(.W(PW)) u_skid (
        .clk_i         (user_clk),
        .rst_i         (user_reset),
        .in_data_i     (sel_payload),
        .in_push_i     (push),
        .in_not_full_o (skid_not_full),
        .out_data_o    ({m_axis_tx_tlast, m_axis_tx_tuser, m_axis_tx_tkeep, m_axis_tx_tdata}),
        .out_valid_o   (m_axis_tx_tvalid),
        .out_ready_i   (m_axis_tx_tready)
    );

    assign grant_ch = grant_q;
    assign busy     = (state_q == XFER);
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Directed bench for pcie_tx_arbiter with four channels: a queue-based source
// per channel, an output collector, and hand-built expected beat sequences.
module tb_pcie_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int KW = 8;
    localparam int BW = DW + KW + 5;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N*DW-1:0]   s_tdata = '0;
    logic [N*KW-1:0]   s_tkeep = '0;
    logic [N*4-1:0]    s_tuser = '0;
    logic [N-1:0]      s_tlast = '0;
    logic [N-1:0]      s_tvalid = '0;
    logic [N-1:0]      s_tready;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic [3:0]        m_tuser;
    logic              m_tlast, m_tvalid;
    logic              m_tready = 1'b1;
    logic [5:0]        tx_buf_av = 6'd10;
    logic              tx_err_drop = 1'b0;
    logic [1:0]        grant_ch;
    logic              busy;
    logic [15:0]       drop_cnt;
    logic [BW-1:0]     mout;

    logic [BW-1:0]     srcq[N][$];
    logic [BW-1:0]     outq[$];
    logic [N-1:0]      hs;
    logic              stall_chk = 1'b0;
    logic              prev_stall = 1'b0;
    logic [BW-1:0]     prev_beat = '0;
    int                checks = 0;
    int                errors = 0;

    always #5 clk = ~clk;

    pcie_tx_arbiter #(.N_CH(N), .C_DATA_WIDTH(DW), .KEEP_WIDTH(KW), .BUF_MIN(2)) dut (
        .user_clk         (clk),
        .user_reset       (rst),
        .s_tdata          (s_tdata),
        .s_tkeep          (s_tkeep),
        .s_tuser          (s_tuser),
        .s_tlast          (s_tlast),
        .s_tvalid         (s_tvalid),
        .s_tready         (s_tready),
        .m_axis_tx_tdata  (m_tdata),
        .m_axis_tx_tkeep  (m_tkeep),
        .m_axis_tx_tuser  (m_tuser),
        .m_axis_tx_tlast  (m_tlast),
        .m_axis_tx_tvalid (m_tvalid),
        .m_axis_tx_tready (m_tready),
        .tx_buf_av        (tx_buf_av),
        .tx_err_drop      (tx_err_drop),
        .grant_ch         (grant_ch),
        .busy             (busy),
        .drop_cnt         (drop_cnt)
    );

    assign mout = {m_tlast, m_tuser, m_tkeep, m_tdata};

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] mkbeat(input int c, input int p, input int b, input logic last);
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [3:0]    u;
        d = {16'hA5C3, 8'(c), 8'(p), 16'h0000, 16'(b)};
        k = last ? 8'h0F : 8'hFF;
        u = 4'(c + p + 1);
        return {last, u, k, d};
    endfunction

    task automatic push_pkt(input int c, input int p, input int n);
        for (int b = 0; b < n; b++) srcq[c].push_back(mkbeat(c, p, b, b == n - 1));
    endtask

    task automatic drive_src();
        logic [BW-1:0] h;
        for (int c = 0; c < N; c++) begin
            h = (srcq[c].size() != 0) ? srcq[c][0] : '0;
            s_tvalid[c]          = (srcq[c].size() != 0);
            s_tlast[c]           = h[BW-1];
            s_tuser[c*4 +: 4]    = h[BW-2 -: 4];
            s_tkeep[c*KW +: KW]  = h[DW+KW-1 -: KW];
            s_tdata[c*DW +: DW]  = h[DW-1:0];
        end
    endtask

    // Source and collector: handshakes sampled at negedge, queues advanced after posedge.
    always begin
        @(negedge clk);
        for (int c = 0; c < N; c++) hs[c] = s_tvalid[c] && s_tready[c];
        if (m_tvalid && m_tready) outq.push_back(mout);
        if (stall_chk && prev_stall) check_val("stall_hold", 128'(mout), 128'(prev_beat));
        prev_stall = m_tvalid && !m_tready;
        prev_beat  = mout;
        @(posedge clk);
        #1;
        for (int c = 0; c < N; c++)
            if (hs[c] && srcq[c].size() != 0) void'(srcq[c].pop_front());
        drive_src();
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int c = 0; c < N; c++) srcq[c].delete();
        outq.delete();
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic wait_out(input int n, input int budget);
        for (int i = 0; i < budget && outq.size() < n; i++) cyc();
        check_val("beat_count", 128'(outq.size()), 128'(n));
    endtask

    task automatic cmp_beat(input string tag, input int idx, input logic [BW-1:0] exp);
        logic [BW-1:0] obs;
        obs = (idx < outq.size()) ? outq[idx] : '0;
        check_val(tag, 128'(obs), 128'(exp));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ch2[5];
        int pk2[5];
        int viol;
        int k;
        ch2 = '{0, 1, 2, 3, 0};
        pk2 = '{0, 0, 0, 0, 1};

        // Reset state
        #1 rst = 1'b1;
        #2;
        check_val("rst_tready", 128'(s_tready), 128'(0));
        check_val("rst_tvalid", 128'(m_tvalid), 128'(0));
        check_val("rst_busy",   128'(busy),     128'(0));
        check_val("rst_drop",   128'(drop_cnt), 128'(0));
        check_val("rst_grant",  128'(grant_ch), 128'(0));
        cyc();
        cyc();
        rst = 1'b0;
        cyc();

        // T1: single 4-beat packet on channel 0
        push_pkt(0, 0, 4);
        cyc();
        check_val("t1_arb_busy",  128'(busy),     128'(0));
        check_val("t1_arb_rdy",   128'(s_tready), 128'(0));
        cyc();
        check_val("t1_xfer_busy", 128'(busy),     128'(1));
        check_val("t1_xfer_rdy",  128'(s_tready), 128'(4'b0001));
        check_val("t1_grant",     128'(grant_ch), 128'(0));
        cyc();
        check_val("t1_lat_valid", 128'(m_tvalid), 128'(1));
        check_val("t1_lat_data",  128'(mout),     128'(mkbeat(0, 0, 0, 1'b0)));
        wait_out(4, 40);
        for (int b = 0; b < 4; b++) cmp_beat("t1_beat", b, mkbeat(0, 0, b, b == 3));
        check_val("t1_drop",      128'(drop_cnt), 128'(0));
        check_val("t1_idle_busy", 128'(busy),     128'(0));
        check_val("t1_idle_vld",  128'(m_tvalid), 128'(0));

        // T2: all four channels requesting, 2-beat packets, round-robin order 0,1,2,3,0
        do_reset();
        push_pkt(0, 0, 2);
        push_pkt(1, 0, 2);
        push_pkt(2, 0, 2);
        push_pkt(3, 0, 2);
        push_pkt(0, 1, 2);
        wait_out(10, 100);
        k = 0;
        for (int p = 0; p < 5; p++) begin
            for (int b = 0; b < 2; b++) begin
                cmp_beat("t2_beat", k, mkbeat(ch2[p], pk2[p], b, b == 1));
                k++;
            end
        end

        // T3: channel 0 requests while channel 1 is mid-packet
        do_reset();
        push_pkt(1, 0, 4);
        for (int i = 0; i < 20 && !busy; i++) cyc();
        check_val("t3_grant", 128'(grant_ch), 128'(1));
        push_pkt(0, 0, 2);
        viol = 0;
        for (int i = 0; i < 60 && outq.size() < 6; i++) begin
            cyc();
            if (srcq[1].size() != 0 && s_tready[0]) viol++;
        end
        check_val("t3_rdy0_held", 128'(viol), 128'(0));
        check_val("t3_count", 128'(outq.size()), 128'(6));
        for (int b = 0; b < 4; b++) cmp_beat("t3_ch1", b, mkbeat(1, 0, b, b == 3));
        for (int b = 0; b < 2; b++) cmp_beat("t3_ch0", 4 + b, mkbeat(0, 0, b, b == 1));

        // T4: tx_buf_av below BUF_MIN blocks the grant
        do_reset();
        tx_buf_av = 6'd1;
        push_pkt(0, 0, 1);
        cyc();
        cyc();
        cyc();
        check_val("t4_nogrant_busy", 128'(busy),     128'(0));
        check_val("t4_nogrant_rdy",  128'(s_tready), 128'(0));
        tx_buf_av = 6'd2;
        cyc();
        check_val("t4_grant_busy",   128'(busy),     128'(1));
        check_val("t4_grant_rdy",    128'(s_tready), 128'(4'b0001));
        wait_out(1, 20);
        cmp_beat("t4_beat", 0, mkbeat(0, 0, 0, 1'b1));

        // T5: tready toggling during an 8-beat packet, tx_buf_av dropped after grant
        do_reset();
        tx_buf_av = 6'd10;
        m_tready  = 1'b1;
        push_pkt(2, 0, 8);
        stall_chk = 1'b1;
        for (int i = 0; i < 20 && !busy; i++) cyc();
        check_val("t5_grant", 128'(grant_ch), 128'(2));
        tx_buf_av = 6'd0;
        for (int i = 0; i < 80 && outq.size() < 8; i++) begin
            m_tready = ~m_tready;
            cyc();
        end
        m_tready = 1'b1;
        for (int i = 0; i < 6; i++) cyc();
        stall_chk = 1'b0;
        check_val("t5_count", 128'(outq.size()), 128'(8));
        for (int b = 0; b < 8; b++) cmp_beat("t5_beat", b, mkbeat(2, 0, b, b == 7));
        tx_buf_av = 6'd10;

        // T6: drop counter increments, saturates, and clears on mid-packet reset
        do_reset();
        tx_err_drop = 1'b1;
        cyc();
        cyc();
        cyc();
        check_val("t6_drop3", 128'(drop_cnt), 128'(3));
        for (int i = 0; i < 65537; i++) cyc();
        check_val("t6_drop_sat", 128'(drop_cnt), 128'(16'hFFFF));
        tx_err_drop = 1'b0;
        m_tready    = 1'b0;
        push_pkt(0, 0, 4);
        for (int i = 0; i < 20 && !m_tvalid; i++) cyc();
        check_val("t6_inflight", 128'(m_tvalid), 128'(1));
        #1;
        rst = 1'b1;
        for (int c = 0; c < N; c++) srcq[c].delete();
        #1;
        check_val("t6_rst_vld",  128'(m_tvalid), 128'(0));
        check_val("t6_rst_drop", 128'(drop_cnt), 128'(0));
        check_val("t6_rst_rdy",  128'(s_tready), 128'(0));
        check_val("t6_rst_busy", 128'(busy),     128'(0));
        cyc();
        cyc();
        rst      = 1'b0;
        m_tready = 1'b1;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
